// File: rtl/spi_xfer_scheduler_pkg.sv
// Shared types and sizing for the SPI transaction scheduler.
// Holds the FSM encoding, byte limits and counter widths.
package spi_xfer_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOAD,
      S_WAIT,
      S_RESP,
      S_GAP
   } state_t;

   localparam int MAX_BYTES = 4;
   localparam int BCNT_W    = 3;
   localparam int TO_W      = 16;

   // Requested lengths above MAX_BYTES run as full-width transactions
   function automatic logic [BCNT_W-1:0] clamp_len(input logic [2:0] len);
      return (len > 3'(MAX_BYTES)) ? BCNT_W'(MAX_BYTES) : len;
   endfunction

endpackage

// File: rtl/spi_xfer_scheduler_arb.sv
// Two-way round-robin arbiter; the last-served pointer advances
// on the one-hot update strobe (the completion pulse).
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic [1:0] i_upd,
   output logic [1:0] o_gnt
);

   logic r_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_last <= 1'b1;
      else if (|i_upd)
         r_last <= i_upd[1];
   end

   always_comb begin
      o_gnt = i_req;
      if (&i_req)
         o_gnt = r_last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one byte-level SPI master between two clients, framing
// 1-4 byte transactions with per-client chip-select and gaps.
module spi_xfer_scheduler
   import spi_xfer_scheduler_pkg::*;
#(
   parameter int CS_SETUP = 2,
   parameter int CS_GAP   = 4,
   parameter int TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [2:0]  len0,
   input  logic [2:0]  len1,
   input  logic [31:0] tx0,
   input  logic [31:0] tx1,
   output logic [1:0]  gnt,
   output logic [1:0]  ack,
   output logic        err,
   output logic [31:0] rx_data,
   output logic [1:0]  cs_n,
   output logic        m_start,
   output logic [7:0]  m_data_in,
   input  logic        m_busy,
   input  logic        m_done,
   input  logic [7:0]  m_data_out
);

   state_t            r_state;
   logic [1:0]        r_gnt;
   logic [1:0]        r_ack;
   logic [1:0]        r_cs_n;
   logic              r_err;
   logic              r_null;
   logic              r_m_start;
   logic [7:0]        r_m_data;
   logic [31:0]       r_rx_data;
   logic [31:0]       r_tx;
   logic [31:0]       r_rx;
   logic [BCNT_W-1:0] r_left;
   logic [TO_W-1:0]   r_cnt;
   logic [TO_W-1:0]   r_to;

   logic [1:0]        w_win;
   logic [BCNT_W-1:0] w_len;
   logic [31:0]       w_tx;
   logic [4:0]        w_sh;
   logic              w_fire;
   logic [31:0]       w_rx_next;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (req),
      .i_upd (r_ack),
      .o_gnt (w_win)
   );

   // tx is left-aligned at grant so the next byte is always [31:24]
   always_comb begin
      w_len     = clamp_len(w_win[1] ? len1 : len0);
      w_tx      = w_win[1] ? tx1 : tx0;
      w_sh      = {2'(3'(MAX_BYTES) - w_len), 3'b000};
      w_rx_next = {r_rx[23:0], m_data_out};
      w_fire    = !m_busy &&
                  ((r_state == S_LOAD) ||
                   (r_state == S_SETUP && r_cnt == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_gnt     <= 2'b00;
         r_ack     <= 2'b00;
         r_cs_n    <= 2'b11;
         r_err     <= 1'b0;
         r_null    <= 1'b0;
         r_m_start <= 1'b0;
         r_m_data  <= 8'h00;
         r_rx_data <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_left    <= '0;
         r_cnt     <= '0;
         r_to      <= '0;
      end else begin
         r_m_start <= 1'b0;
         r_ack     <= 2'b00;
         unique case (r_state)
            S_IDLE: begin
               if (|w_win) begin
                  r_gnt  <= w_win;
                  r_rx   <= '0;
                  r_tx   <= w_tx << w_sh;
                  r_left <= w_len;
                  if (w_len == '0) begin
                     r_null    <= 1'b1;
                     r_ack     <= w_win;
                     r_rx_data <= '0;
                     r_err     <= 1'b0;
                     r_state   <= S_RESP;
                  end else begin
                     r_null  <= 1'b0;
                     r_cs_n  <= ~w_win;
                     r_cnt   <= TO_W'(CS_SETUP - 1);
                     r_state <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               if (r_cnt != '0)
                  r_cnt <= r_cnt - 1'b1;
               else
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
            end
            S_WAIT: begin
               if (m_done) begin
                  r_rx   <= w_rx_next;
                  r_left <= r_left - 1'b1;
                  if (r_left == BCNT_W'(1)) begin
                     r_ack     <= r_gnt;
                     r_rx_data <= w_rx_next;
                     r_err     <= 1'b0;
                     r_state   <= S_RESP;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end else if (r_to == '0) begin
                  r_ack     <= r_gnt;
                  r_rx_data <= r_rx;
                  r_err     <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_to <= r_to - 1'b1;
               end
            end
            S_RESP: begin
               r_gnt  <= 2'b00;
               r_cs_n <= 2'b11;
               r_err  <= 1'b0;
               r_cnt  <= TO_W'(CS_GAP - 1);
               r_state <= r_null ? S_IDLE : S_GAP;
            end
            S_GAP: begin
               if (r_cnt != '0)
                  r_cnt <= r_cnt - 1'b1;
               else
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_fire) begin
            r_m_start <= 1'b1;
            r_m_data  <= r_tx[31:24];
            r_tx      <= {r_tx[23:0], 8'h00};
            r_to      <= TO_W'(TIMEOUT - 1);
            r_state   <= S_WAIT;
         end
      end
   end

   assign gnt       = r_gnt;
   assign ack       = r_ack;
   assign err       = r_err;
   assign rx_data   = r_rx_data;
   assign cs_n      = r_cs_n;
   assign m_start   = r_m_start;
   assign m_data_in = r_m_data;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Bench for spi_xfer_scheduler: byte-master model plus a
// transaction-level reference for order, bytes, rx and err.
module tb_spi_xfer_scheduler;

   localparam int CS_SETUP = 2;
   localparam int CS_GAP   = 4;
   localparam int TIMEOUT  = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [2:0]  len0, len1;
   logic [31:0] tx0, tx1;
   logic [1:0]  gnt, ack, cs_n;
   logic        err, m_start;
   logic [31:0] rx_data;
   logic [7:0]  m_data_in;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [7:0]  m_data_out = 8'h00;

   always #5 clk = ~clk;

   spi_xfer_scheduler #(
      .CS_SETUP (CS_SETUP),
      .CS_GAP   (CS_GAP),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .len0       (len0),
      .len1       (len1),
      .tx0        (tx0),
      .tx1        (tx1),
      .gnt        (gnt),
      .ack        (ack),
      .err        (err),
      .rx_data    (rx_data),
      .cs_n       (cs_n),
      .m_start    (m_start),
      .m_data_in  (m_data_in),
      .m_busy     (m_busy),
      .m_done     (m_done),
      .m_data_out (m_data_out)
   );

   int n_vec = 0;
   int n_bad = 0;
   int last_served = 1;

   logic [7:0] resp_q[$];
   logic [7:0] sent_q[$];
   int n_starts = 0;
   int n_dones  = 0;
   int hang_at  = 0;
   int bm_cnt   = 0;
   bit rand_busy = 1'b0;
   bit hang_this = 1'b0;

   // Byte master: accepts m_start, stays busy a random time, then
   // returns the next queued response (or nothing when hung).
   always @(negedge clk) begin
      m_done = 1'b0;
      if (reset) begin
         bm_cnt = 0;
         m_busy = 1'b0;
      end else if (bm_cnt > 0) begin
         bm_cnt--;
         m_data_out = 8'($urandom);
         if (bm_cnt == 0) begin
            m_busy = 1'b0;
            if (!hang_this) begin
               m_done = 1'b1;
               n_dones++;
               m_data_out = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hEE;
            end
         end
      end else if (m_start) begin
         sent_q.push_back(m_data_in);
         n_starts++;
         hang_this = (n_starts == hang_at);
         m_busy = 1'b1;
         bm_cnt = $urandom_range(1, 5);
      end else begin
         m_busy     = rand_busy && ($urandom_range(0, 3) == 0);
         m_done     = rand_busy && ($urandom_range(0, 7) == 0);
         m_data_out = 8'($urandom);
      end
   end

   int inv_viol = 0;
   int min_gap  = 1000;
   int hi_run   = 0;
   bit run_valid = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         run_valid = 1'b0;
         hi_run    = 0;
      end else begin
         if (cs_n == 2'b00 || ((~cs_n) & ~gnt) != 2'b00)
            inv_viol++;
         if (cs_n == 2'b11) begin
            hi_run++;
         end else begin
            if (run_valid && hi_run > 0 && hi_run < min_gap)
               min_gap = hi_run;
            run_valid = 1'b1;
            hi_run    = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [1:0] mask,
                      input logic [2:0] l0, input logic [31:0] t0,
                      input logic [2:0] l1, input logic [31:0] t1,
                      input bit early, input int hang, input bit chk_lat,
                      input logic [31:0] rsp_w, input bit use_rsp);
      int order[$];
      logic [7:0] exp_sent[$];
      logic [31:0] exp_rx[$], got_rx[$];
      logic exp_err[$], got_err[$];
      int exp_dn[$], got_dn[$], got_c[$];
      logic [2:0] l;
      logic [31:0] t, rx;
      logic [7:0] r;
      logic e;
      logic [1:0] gprev, newg;
      int c, nb, dn, acks, cyc, gcyc, scyc, bound;
      bit cs_next, stop;

      if (mask == 2'b11) begin
         order.push_back(last_served == 1 ? 0 : 1);
         order.push_back(last_served == 1 ? 1 : 0);
      end else begin
         order.push_back(mask[1] ? 1 : 0);
      end
      resp_q.delete();
      sent_q.delete();
      n_starts = 0;
      n_dones  = 0;
      hang_at  = hang;
      dn = 0;
      foreach (order[k]) begin
         c  = order[k];
         l  = c ? l1 : l0;
         t  = c ? t1 : t0;
         nb = (l > 3'd4) ? 4 : int'(l);
         rx = '0;
         e  = 1'b0;
         stop = 1'b0;
         for (int i = 0; i < nb && !stop; i++) begin
            r = use_rsp ? rsp_w[8*(nb-1-i) +: 8] : 8'($urandom);
            exp_sent.push_back(t[8*(nb-1-i) +: 8]);
            if (exp_sent.size() == hang) begin
               e = 1'b1;
               stop = 1'b1;
            end else begin
               resp_q.push_back(r);
               rx = (rx << 8) | 32'(r);
               dn++;
            end
         end
         exp_rx.push_back(rx);
         exp_err.push_back(e);
         exp_dn.push_back(dn);
      end

      @(negedge clk);
      len0 = l0; tx0 = t0;
      len1 = l1; tx1 = t1;
      req  = mask;
      gprev = 2'b00;
      acks = 0; cyc = 0; gcyc = -1; scyc = -1;
      cs_next = 1'b0;
      bound = 40 + order.size() * (CS_SETUP + CS_GAP + 60 + TIMEOUT);
      while (acks < order.size() && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (cs_next) begin
            chk("cs_release", 32'(cs_n), 32'h3);
            cs_next = 1'b0;
         end
         newg  = gnt & ~gprev;
         gprev = gnt;
         if (newg != 2'b00 && gcyc < 0) gcyc = cyc;
         if (m_start && scyc < 0) scyc = cyc;
         if (newg[0]) begin
            len0 = 3'($urandom); tx0 = $urandom;
            if (early) req[0] = 1'b0;
         end
         if (newg[1]) begin
            len1 = 3'($urandom); tx1 = $urandom;
            if (early) req[1] = 1'b0;
         end
         if (ack != 2'b00) begin
            chk("gnt_at_ack", 32'(gnt), 32'(ack));
            got_c.push_back(ack[1] ? 1 : 0);
            got_rx.push_back(rx_data);
            got_err.push_back(err);
            got_dn.push_back(n_dones);
            req = req & ~ack;
            acks++;
            cs_next = 1'b1;
         end
      end
      if (cs_next) begin
         @(negedge clk);
         chk("cs_release", 32'(cs_n), 32'h3);
         chk("ack_pulse", 32'(ack), 32'h0);
      end
      req = 2'b00;
      chk("ack_count", 32'(acks), 32'(order.size()));
      for (int k = 0; k < order.size(); k++) begin
         if (k < got_c.size()) begin
            chk("owner", 32'(got_c[k]), 32'(order[k]));
            chk("rx_data", got_rx[k], exp_rx[k]);
            chk("err", 32'(got_err[k]), 32'(exp_err[k]));
            chk("dones_at_ack", 32'(got_dn[k]), 32'(exp_dn[k]));
         end
      end
      chk("n_starts", 32'(sent_q.size()), 32'(exp_sent.size()));
      for (int k = 0; k < exp_sent.size(); k++)
         if (k < sent_q.size())
            chk("tx_byte", 32'(sent_q[k]), 32'(exp_sent[k]));
      if (chk_lat)
         chk("setup_lat", 32'(scyc - gcyc), 32'(CS_SETUP));
      last_served = order[order.size()-1];
   endtask

   initial begin
      int acks_after;
      logic [1:0] mask;
      bit early;

      reset = 1'b1;
      req = 2'b00;
      len0 = '0; len1 = '0;
      tx0 = '0; tx1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rx", rx_data, 32'h0);
      chk("rst_cs", 32'(cs_n), 32'h3);
      chk("rst_start", 32'(m_start), 32'h0);
      chk("rst_mdata", 32'(m_data_in), 32'h0);
      reset = 1'b0;

      run(2'b11, 3'd2, $urandom, 3'd3, $urandom, 0, 0, 0, 0, 0);
      run(2'b11, 3'd1, $urandom, 3'd4, $urandom, 0, 0, 0, 0, 0);
      run(2'b01, 3'd2, 32'h0000_A55A, 3'd0, 0, 0, 0, 1, 32'h3CC3, 1);
      run(2'b01, 3'd0, $urandom, 3'd0, 0, 0, 0, 0, 0, 0);
      run(2'b10, 3'd0, 0, 3'd7, 32'h1122_3344, 0, 0, 1, 0, 0);

      rand_busy = 1'b1;
      for (int n = 0; n < 10; n++) begin
         mask  = 2'($urandom_range(1, 3));
         early = (mask != 2'b11) && ($urandom_range(0, 1) == 1);
         run(mask, 3'($urandom), $urandom, 3'($urandom), $urandom,
             early, 0, 0, 0, 0);
      end
      rand_busy = 1'b0;

      run(2'b01, 3'd3, $urandom, 3'd0, 0, 0, 2, 0, 0, 0);

      @(negedge clk);
      len1 = 3'd4; tx1 = $urandom; req = 2'b10;
      repeat (CS_SETUP + 4) @(negedge clk);
      reset = 1'b1;
      req = 2'b00;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_ack", 32'(ack), 32'h0);
      chk("mid_rst_err", 32'(err), 32'h0);
      chk("mid_rst_rx", rx_data, 32'h0);
      chk("mid_rst_cs", 32'(cs_n), 32'h3);
      chk("mid_rst_start", 32'(m_start), 32'h0);
      chk("mid_rst_mdata", 32'(m_data_in), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      resp_q.delete();
      last_served = 1;
      acks_after = 0;
      repeat (30) begin
         @(negedge clk);
         if (ack != 2'b00) acks_after++;
      end
      chk("no_ack_after_rst", 32'(acks_after), 32'h0);

      run(2'b11, 3'd3, $urandom, 3'd2, $urandom, 0, 0, 0, 0, 0);

      chk("cs_invariant", 32'(inv_viol), 32'h0);
      chk("min_gap_ok", 32'(min_gap >= CS_GAP), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_xfer_scheduler.md
# spi_xfer_scheduler

Two-requester transaction scheduler that sits in front of the byte-level SPI master and shares it between two clients. The block arbitrates round-robin and runs a 1–4 byte transaction for the winner. It issues one byte-start per byte, collects the received bytes, and holds a per-client device chip-select low across the whole transaction. It provides the multi-byte framing and inter-transaction gap that the byte engine does not provide.

## Interface
Parameters:
- CS_SETUP, 2, clk cycles between cs_n falling and the first m_start (≥1)
- CS_GAP, 4, clk cycles cs_n held high after a transaction before the next grant (≥1)
- TIMEOUT, 4096, clk cycles allowed per byte for m_done before abort

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  2  per-client request, level; held until ack
- len0, len1  in  3 each  byte count; 1–4 valid, >4 clamps to 4, 0 = null transaction
- tx0, tx1  in  32 each  transmit bytes, right-aligned; byte tx[8*len-1 -: 8] goes first, tx[7:0] goes last
- gnt  out  2  one-hot owner; high from grant through the ack cycle
- ack  out  2  one-cycle completion pulse to the owner
- err  out  1  high with ack when the transaction timed out
- rx_data  out  32  received bytes, right-aligned (last byte in [7:0]); valid in the ack cycle, held until the next ack
- cs_n  out  2  per-client device select, active-low
- m_start  out  1  one-cycle byte start to the byte master
- m_data_in  out  8  byte to send; valid while m_start is high
- m_busy  in  1  byte master busy
- m_done  in  1  byte master completion pulse
- m_data_out  in  8  received byte; sampled when m_done is high

## Operation
- States: IDLE → SETUP → LOAD → WAIT → (LOAD | RESP) → GAP → IDLE.
- IDLE:
  - If any req is high, the arbiter picks a winner, latches its len and tx, clears the rx shift register and sets gnt.
  - len 0 → go directly to RESP with no bus activity and no cs_n toggle; rx_data = 0, err = 0.
  - Otherwise drive cs_n[winner] = 0 and go to SETUP.
- Round-robin: a last-served pointer resets to client 1, so client 0 wins the first contention. On simultaneous requests, the client not served last wins. A lone request always wins.
- SETUP: counts CS_SETUP cycles, then goes to LOAD.
- LOAD:
  - Waits until m_busy = 0.
  - Then pulses m_start for exactly one cycle with the current MSB byte on m_data_in.
  - Reloads the timeout counter and goes to WAIT.
- WAIT:
  - On m_done: rx ← {rx[23:0], m_data_out}, decrement the remaining-byte count.
  - If the count is non-zero, go to LOAD with the next byte; else go to RESP.
  - m_done outside WAIT is ignored.
- Timeout: if the counter expires in WAIT, set the err flag and go to RESP. Bytes received so far stay in rx, right-aligned.
- RESP:
  - One cycle: ack[owner] = 1, rx_data ← rx, err driven.
  - Then gnt and cs_n deassert, the pointer is updated, and the block goes to GAP.
  - A null transaction skips GAP.
- GAP: counts CS_GAP cycles with all cs_n high, then goes to IDLE.
- Requester behaviour:
  - Dropping req after grant does not cancel the transaction; ack still pulses.
  - Changes to len or tx after grant are ignored.
  - A new request from the same client is considered only from IDLE.

## Timing
- Reset values: gnt = 0, ack = 0, err = 0, rx_data = 0, cs_n = 2'b11, m_start = 0, m_data_in = 0; state IDLE, pointer = client 1.
- Reset mid-transaction: everything returns immediately to the reset values. No ack is issued and the transaction is lost.
- Request latency: req sampled high at edge N → gnt and cs_n low from N+1. The first m_start is at N+1+CS_SETUP if m_busy is low.
- Inter-byte timing: m_done at edge K → next m_start no earlier than K+1, and only when m_busy = 0.
- Completion: the last m_done at edge K → ack at K+1. cs_n rises at K+2.
- Throughput: minimum spacing between two ack pulses is 1 + CS_GAP + CS_SETUP + the byte-time sum.
- cs_n: never low for two clients at once. A client's cs_n is never low outside its gnt.

## Structure
- Shared package holds:
  - state encoding: IDLE, SETUP, LOAD, WAIT, RESP, GAP
  - MAX_BYTES = 4
  - byte-count and timeout counter widths
- Sub-module rr_arbiter2: inputs req[1:0] and an update strobe; output one-hot grant; owns the last-served pointer. Everything else stays in the top-level FSM.

## Test plan
- Single request: req0 = 1, len0 = 2, tx0 = 0x0000_A55A, bytes 0x3C then 0xC3 returned. Required: byte A5 sent then 5A; rx_data = 0x0000_3CC3; one ack[0] pulse; cs_n[0] low throughout, cs_n[1] high.
- Contention: req = 2'b11 from reset. Required: client 0 served first, then client 1; a second contention after that serves client 0 again; gaps of ≥ CS_GAP cycles with both cs_n high.
- len0 = 0: required ack[0] the cycle after grant, rx_data = 0, no m_start pulse, cs_n unchanged.
- len1 = 7, tx1 = 0x1122_3344: required exactly 4 m_start pulses (11, 22, 33, 44); ack[1] after the 4th m_done.
- m_done withheld for TIMEOUT cycles on byte 2 of 3: required err = 1 with ack; rx_data holds only byte 1; cs_n high afterwards. Then a reset asserted mid-transaction: all outputs at reset values, no ack.
